hbm_rd_request: RTL and testbench
=================================

Name: hbm_rd_request

Overview:
- AXI3 read-address (AR) initiator toward one HBM pseudo-channel.
- Issues tagged read bursts for the A (feature) region and the B (label) region of each SGD epoch. The R-channel dispatcher returns the responses to the banks by tag.
- Limits in-flight bursts with a credit counter driven by snooped RLAST beats, and sequences multiple epochs.

Parameters:
- ADDR_WIDTH, 33, HBM byte-address width.
- ID_WIDTH, 6, ARID width; must match the dispatcher's RID width.
- BURST_BEATS, 16, maximum beats per burst (AXI3 limit); power of two.
- MAX_OUTSTANDING, 32, maximum accepted AR bursts without a returned RLAST.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle pulse; latches configuration and begins.
- addr_a  in  ADDR_WIDTH  A region base; 512-byte aligned.
- addr_b  in  ADDR_WIDTH  B region base; 512-byte aligned.
- data_length  in  32  A region bytes per epoch.
- b_length  in  32  B region bytes per epoch.
- num_epochs  in  32  epoch count; 0 is treated as 1.
- m_axi_ARVALID  out  1  address valid.
- m_axi_ARREADY  in  1  address ready.
- m_axi_ARADDR  out  ADDR_WIDTH  burst start address.
- m_axi_ARID  out  ID_WIDTH  MEM_RD_A_TAG or MEM_RD_B_TAG.
- m_axi_ARLEN  out  4  beats-1.
- m_axi_ARSIZE  out  3  constant 3'b101 (32 B).
- m_axi_ARBURST  out  2  constant 2'b01 (INCR).
- m_axi_RVALID  in  1  snooped read-data valid.
- m_axi_RREADY  in  1  snooped read-data ready (driven by dispatcher).
- m_axi_RLAST  in  1  snooped read-data last.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse when all epochs are complete.
- ar_a_counter  out  32  A bursts accepted since start.
- ar_b_counter  out  32  B bursts accepted since start.
- stall_counter  out  32  stall cycles; active only with the optional feature.

Behaviour:
- Reset and clocking: reset rst_n, synchronous, active-low; clock clk. Reset clears all state mid-operation, including outstanding bursts; no drain.
- Reset values: ARVALID=0, ARADDR=0, ARID=0, ARLEN=0, busy=0, done=0, all counters=0. ARSIZE and ARBURST are constant.
- Beat calculation: beats = ceil(length/32). A length that is not a multiple of 32 rounds up.
- Burst shape: full bursts use ARLEN=BURST_BEATS-1. The final burst uses ARLEN=remaining_beats-1.
- Address: increments by BURST_BEATS*32 per burst. Bases are 512-aligned, so no burst crosses a 4 KB boundary.
- FSM states:
  - IDLE: start latches all inputs, zeroes the counters, sets busy, goes to ISSUE_B.
  - ISSUE_B: issues B bursts until the B beats are exhausted, then goes to ISSUE_A. If b_length=0, goes to ISSUE_A immediately.
  - ISSUE_A: same for A, then goes to DRAIN. If data_length=0, goes to DRAIN immediately.
  - DRAIN: waits for outstanding==0. Then, if epochs remain, reloads addr_a/addr_b and the lengths, increments the epoch count, goes to ISSUE_B. Otherwise pulses done, clears busy, goes to IDLE.
- AR handshake:
  - ARVALID, once asserted, holds with stable ARADDR/ARID/ARLEN until the cycle ARVALID&ARREADY.
  - The next burst may be presented in the cycle after acceptance. Sustained throughput is one burst per cycle when ARREADY is held high.
  - New ARVALID is asserted only if outstanding<MAX_OUTSTANDING. A burst already presented is never withdrawn.
- Credit (outstanding) counter:
  - Increments on AR handshake.
  - Decrements on RVALID&RREADY&RLAST.
  - When both occur in the same cycle, the value is unchanged.
  - Never underflows: a decrement at 0 is ignored.
  - Width is clog2(MAX_OUTSTANDING+1).
- Counters: ar_a_counter and ar_b_counter increment on AR handshake with the matching ARID and do not wrap-check.
- start while busy is ignored.
- Latency: start to first ARVALID is 2 cycles.

Optional Feature:
- Macro: HBM_RD_REQ_STATS_EN.
- Defined: stall_counter increments each cycle that ARVALID&~ARREADY holds, or that the block is in ISSUE_A/ISSUE_B with outstanding==MAX_OUTSTANDING. It clears on start.
- Undefined: stall_counter is tied to 0 and no counter logic is synthesised. The port exists in both builds.

Decomposition:
- Shared package hbm_pkg:
  - MEM_RD_A_TAG and MEM_RD_B_TAG, shared with the dispatcher.
  - BEAT_BYTES=32, AR_SIZE_32B, AR_BURST_INCR.
  - FSM state enum.
- Sub-module hbm_rd_credit_counter: inc, dec, max -> count, has_credit, empty.

Test Plan:
- Single epoch: data_length=1024, b_length=96, num_epochs=1, ARREADY=1, one RLAST returned per burst -> one B burst (ARLEN=2, ARID=B_TAG, addr_b), then two A bursts (ARLEN=15, addresses addr_a and addr_a+512); done pulses once; ar_a_counter=2, ar_b_counter=1.
- Partial tail: data_length=530, b_length=0 -> A bursts ARLEN=15 then ARLEN=0; no B bursts issued.
- Backpressure: ARREADY low for 10 cycles with a burst presented -> ARVALID/ARADDR/ARID/ARLEN stable throughout; with STATS_EN, stall_counter=10.
- Credit limit: MAX_OUTSTANDING=4, data_length=4096, no RLAST returned -> exactly 4 bursts accepted, ARVALID stays low. One RLAST returned -> 5th burst issued. Simultaneous handshake and RLAST -> count unchanged.
- Multi-epoch: num_epochs=3, data_length=512, b_length=32 -> B,A,B,A,B,A order; addresses restart at the bases each epoch; no epoch's first burst issued before the prior DRAIN sees outstanding==0; done after the third epoch.
- Reset mid-ISSUE_A with 3 outstanding -> next cycle all outputs at reset values; a new start runs cleanly from zero counters.

Source files
------------

// File: rtl/hbm_pkg.sv
// Shared definitions for the HBM read-request path: AXI constants, response
// tags shared with the R-channel dispatcher, the request FSM state type and
// the byte-length to beat-count helper.
package hbm_pkg;

  localparam int          BEAT_BYTES    = 32;
  localparam logic [2:0]  AR_SIZE_32B   = 3'b101;
  localparam logic [1:0]  AR_BURST_INCR = 2'b01;

  // Tags carried on ARID; the dispatcher routes returning beats by these.
  localparam logic [5:0]  MEM_RD_A_TAG  = 6'h01;
  localparam logic [5:0]  MEM_RD_B_TAG  = 6'h02;

  // Beat counts derived from a 32-bit byte length fit in 28 bits.
  localparam int          BEATS_W       = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE_B,
    ST_ISSUE_A,
    ST_DRAIN
  } rd_state_e;

  // ceil(len_bytes / 32), computed one bit wider so a length near 2^32 rounds up correctly.
  function automatic logic [BEATS_W-1:0] len_to_beats(input logic [31:0] len_bytes);
    logic [32:0] sum;
    sum = {1'b0, len_bytes} + 33'd31;
    return sum[32:5];
  endfunction

endpackage

// File: rtl/hbm_rd_request_if.sv
// AXI3 read-address channel toward one HBM pseudo-channel, plus the R-channel
// handshake bits that the request block snoops for credit return.
interface hbm_rd_request_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int ID_WIDTH   = 6
);

  logic                  m_axi_ARVALID;
  logic                  m_axi_ARREADY;
  logic [ADDR_WIDTH-1:0] m_axi_ARADDR;
  logic [ID_WIDTH-1:0]   m_axi_ARID;
  logic [3:0]            m_axi_ARLEN;
  logic [2:0]            m_axi_ARSIZE;
  logic [1:0]            m_axi_ARBURST;
  logic                  m_axi_RVALID;
  logic                  m_axi_RREADY;
  logic                  m_axi_RLAST;

  // Request initiator: drives AR, only observes R.
  modport master (
    output m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN,
           m_axi_ARSIZE, m_axi_ARBURST,
    input  m_axi_ARREADY, m_axi_RVALID, m_axi_RREADY, m_axi_RLAST
  );

  // Memory side together with the dispatcher that owns RREADY.
  modport slave (
    input  m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN,
           m_axi_ARSIZE, m_axi_ARBURST,
    output m_axi_ARREADY, m_axi_RVALID, m_axi_RREADY, m_axi_RLAST
  );

endinterface

// File: rtl/hbm_rd_credit_counter.sv
// Outstanding-burst counter: counts up on AR acceptance, down on a returned
// RLAST beat. A return with nothing outstanding is ignored.
module hbm_rd_credit_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             has_credit,
  output logic             empty
);

  logic [WIDTH-1:0] count_q;
  logic             dec_eff;

  assign dec_eff = dec && (count_q != '0);

  // Track in-flight bursts; simultaneous inc and dec cancel.
  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: reset is synchronous, so rst_n is tested inside the clocked block and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && !dec_eff) begin
      count_q <= count_q + 1'b1;
    end else if (!inc && dec_eff) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count      = count_q;
  assign has_credit = count_q < max;
  assign empty      = count_q == '0;

endmodule

// File: rtl/hbm_rd_request.sv
// AXI3 AR initiator for SGD epochs: per epoch issues the B (label) region,
// then the A (feature) region, then drains outstanding bursts before the next
// epoch. Optional stall statistics are enabled by defining HBM_RD_REQ_STATS_EN.
module hbm_rd_request
  import hbm_pkg::*;
#(
  parameter int ADDR_WIDTH      = 33,
  parameter int ID_WIDTH        = 6,
  parameter int BURST_BEATS     = 16,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [31:0]           data_length,
  input  logic [31:0]           b_length,
  input  logic [31:0]           num_epochs,
  hbm_rd_request_if.master      m_axi,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           ar_a_counter,
  output logic [31:0]           ar_b_counter,
  output logic [31:0]           stall_counter
);

  localparam int                    CNT_W        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]      CREDIT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]      CREDIT_LAST  = CNT_W'(MAX_OUTSTANDING - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_STRIDE = ADDR_WIDTH'(BURST_BEATS * BEAT_BYTES);
  localparam logic [BEATS_W-1:0]    MAX_BEATS    = BEATS_W'(BURST_BEATS);

  rd_state_e             state_q, state_d;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [3:0]            arlen_q;
  logic [ADDR_WIDTH-1:0] base_a_q, base_b_q, cur_a_q, cur_b_q;
  logic [31:0]           len_a_q, len_b_q, epochs_q, epoch_cnt_q;
  logic [BEATS_W-1:0]    rem_a_q, rem_b_q;
  logic                  busy_q, done_q;
  logic [31:0]           a_cnt_q, b_cnt_q;

  logic                  ar_hs, r_last_hs, slot_free, credit_ok;
  logic                  issue_a, issue_b, load_cfg, reload, finish;
  logic [BEATS_W-1:0]    sel_rem, sel_beats;
  logic [CNT_W-1:0]      credit_count;
  logic                  credit_has, credit_empty;

  assign ar_hs     = arvalid_q && m_axi.m_axi_ARREADY;
  assign r_last_hs = m_axi.m_axi_RVALID && m_axi.m_axi_RREADY && m_axi.m_axi_RLAST;
  // A new burst may load when nothing is presented or the presented one leaves this edge.
  assign slot_free = !arvalid_q || ar_hs;
  // Count the burst accepted this edge so the next one never exceeds the limit.
  assign credit_ok = credit_has &&
                     !(ar_hs && !(r_last_hs && !credit_empty) && credit_count == CREDIT_LAST);

  assign sel_rem   = issue_b ? rem_b_q : rem_a_q;
  assign sel_beats = (sel_rem > MAX_BEATS) ? MAX_BEATS : sel_rem;

  hbm_rd_credit_counter #(.WIDTH(CNT_W)) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (ar_hs),
    .dec        (r_last_hs),
    .max        (CREDIT_MAX),
    .count      (credit_count),
    .has_credit (credit_has),
    .empty      (credit_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    issue_a  = 1'b0;
    issue_b  = 1'b0;
    load_cfg = 1'b0;
    reload   = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          state_d  = ST_ISSUE_B;
        end
      end
      ST_ISSUE_B: begin
        if (rem_b_q == '0)             state_d = ST_ISSUE_A;
        else if (slot_free && credit_ok) issue_b = 1'b1;
      end
      ST_ISSUE_A: begin
        if (rem_a_q == '0)             state_d = ST_DRAIN;
        else if (slot_free && credit_ok) issue_a = 1'b1;
      end
      ST_DRAIN: begin
        if (!arvalid_q && credit_empty) begin
          if ((epoch_cnt_q + 32'd1) < epochs_q) begin
            reload  = 1'b1;
            state_d = ST_ISSUE_B;
          end else begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration, region walkers, AR output register and burst counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arid_q      <= '0;
      arlen_q     <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      cur_a_q     <= '0;
      cur_b_q     <= '0;
      len_a_q     <= '0;
      len_b_q     <= '0;
      rem_a_q     <= '0;
      rem_b_q     <= '0;
      epochs_q    <= '0;
      epoch_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
    end else begin
      done_q <= finish;
      if (load_cfg) begin
        base_a_q    <= addr_a;
        base_b_q    <= addr_b;
        cur_a_q     <= addr_a;
        cur_b_q     <= addr_b;
        len_a_q     <= data_length;
        len_b_q     <= b_length;
        rem_a_q     <= len_to_beats(data_length);
        rem_b_q     <= len_to_beats(b_length);
        epochs_q    <= (num_epochs == 32'd0) ? 32'd1 : num_epochs;
        epoch_cnt_q <= '0;
        busy_q      <= 1'b1;
        a_cnt_q     <= '0;
        b_cnt_q     <= '0;
      end else begin
        if (reload) begin
          cur_a_q     <= base_a_q;
          cur_b_q     <= base_b_q;
          rem_a_q     <= len_to_beats(len_a_q);
          rem_b_q     <= len_to_beats(len_b_q);
          epoch_cnt_q <= epoch_cnt_q + 32'd1;
        end
        if (finish) busy_q <= 1'b0;
        if (ar_hs && arid_q == ID_WIDTH'(MEM_RD_A_TAG)) a_cnt_q <= a_cnt_q + 32'd1;
        if (ar_hs && arid_q == ID_WIDTH'(MEM_RD_B_TAG)) b_cnt_q <= b_cnt_q + 32'd1;
        if (issue_b) begin
          cur_b_q <= cur_b_q + BURST_STRIDE;
          rem_b_q <= rem_b_q - sel_beats;
        end
        if (issue_a) begin
          cur_a_q <= cur_a_q + BURST_STRIDE;
          rem_a_q <= rem_a_q - sel_beats;
        end
      end
      if (issue_a || issue_b) begin
        arvalid_q <= 1'b1;
        araddr_q  <= issue_b ? cur_b_q : cur_a_q;
        arid_q    <= issue_b ? ID_WIDTH'(MEM_RD_B_TAG) : ID_WIDTH'(MEM_RD_A_TAG);
        arlen_q   <= 4'(sel_beats - 1'b1);
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end
    end
  end

`ifdef HBM_RD_REQ_STATS_EN
  logic [31:0] stall_q;

  // Cycles lost to slave backpressure or to an exhausted credit pool.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (load_cfg) begin
      stall_q <= '0;
    end else if ((arvalid_q && !m_axi.m_axi_ARREADY) ||
                 ((state_q == ST_ISSUE_A || state_q == ST_ISSUE_B) &&
                  credit_count == CREDIT_MAX)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_counter = stall_q;
`else
  assign stall_counter = '0;
`endif

  assign m_axi.m_axi_ARVALID = arvalid_q;
  assign m_axi.m_axi_ARADDR  = araddr_q;
  assign m_axi.m_axi_ARID    = arid_q;
  assign m_axi.m_axi_ARLEN   = arlen_q;
  assign m_axi.m_axi_ARSIZE  = AR_SIZE_32B;
  assign m_axi.m_axi_ARBURST = AR_BURST_INCR;
  assign busy                = busy_q;
  assign done                = done_q;
  assign ar_a_counter        = a_cnt_q;
  assign ar_b_counter        = b_cnt_q;

endmodule

// File: tb/tb_hbm_rd_request.sv
// Scoreboard bench for hbm_rd_request: stimulus pushes hand-computed AR bursts,
// a negedge monitor pops and compares every accepted burst and models the
// outstanding-burst count while returning RLAST beats.
module tb_hbm_rd_request;
  import hbm_pkg::*;

  localparam int AW   = 33;
  localparam int IW   = 6;
  localparam int MAXO = 4;
  localparam logic [AW-1:0] A_BASE = 33'h1_0000_0000;
  localparam logic [AW-1:0] B_BASE = 33'h0_0020_0000;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [3:0]    len;
  } ar_t;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [AW-1:0] addr_a, addr_b;
  logic [31:0]   data_length, b_length, num_epochs;
  logic          busy, done;
  logic [31:0]   ar_a_counter, ar_b_counter, stall_counter;

  int  n_checks = 0;
  int  n_errors = 0;
  ar_t exp_q[$];
  int  model_out = 0;
  int  hs_count = 0;
  int  done_seen = 0;
  int  rlast_req = 0;
  int  rlast_served = 0;
  bit  auto_rlast = 1'b1;
  bit  chk_drain = 1'b0;

  always #5 clk = ~clk;

  hbm_rd_request_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

  hbm_rd_request #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_BEATS(16), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_length(data_length), .b_length(b_length), .num_epochs(num_epochs),
    .m_axi(axi),
    .busy(busy), .done(done),
    .ar_a_counter(ar_a_counter), .ar_b_counter(ar_b_counter),
    .stall_counter(stall_counter)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [3:0] len);
    ar_t e;
    e.addr = addr;
    e.id   = id;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [31:0] dl, input logic [31:0] bl, input logic [31:0] ne);
    addr_a      = A_BASE;
    addr_b      = B_BASE;
    data_length = dl;
    b_length    = bl;
    num_epochs  = ne;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 3000) begin
      tick();
      i++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
    tick();
    check({name, "_idle"}, 64'({done, busy}), 64'd0);
  endtask

  // Monitor: compare accepted bursts, return RLAST beats, model outstanding count.
  initial begin : monitor
    logic hs;
    bit   drive;
    ar_t  e;
    axi.m_axi_RVALID = 1'b0;
    axi.m_axi_RREADY = 1'b0;
    axi.m_axi_RLAST  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_out = 0;
        exp_q.delete();
        axi.m_axi_RVALID = 1'b0;
        axi.m_axi_RREADY = 1'b0;
        axi.m_axi_RLAST  = 1'b0;
      end else begin
        hs    = axi.m_axi_ARVALID && axi.m_axi_ARREADY;
        drive = 1'b0;
        if (rlast_req > rlast_served) begin
          drive = 1'b1;
          rlast_served++;
        end else if (auto_rlast && model_out > 0) begin
          drive = 1'b1;
        end
        axi.m_axi_RVALID = drive;
        axi.m_axi_RREADY = drive;
        axi.m_axi_RLAST  = drive;
        if (hs) begin
          hs_count++;
          if (chk_drain && axi.m_axi_ARID == IW'(MEM_RD_B_TAG))
            check("epoch_after_drain", 64'(model_out), 64'd0);
          if (exp_q.size() == 0) begin
            check("ar_unexpected", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("ar_burst", 64'({axi.m_axi_ARADDR, axi.m_axi_ARID, axi.m_axi_ARLEN}),
                  64'({e.addr, e.id, e.len}));
          end
        end
        if (done) done_seen++;
        if (drive && model_out > 0) model_out--;
        if (hs) model_out++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int   d0, h0, i;
    rst_n       = 1'b0;
    start       = 1'b0;
    addr_a      = '0;
    addr_b      = '0;
    data_length = '0;
    b_length    = '0;
    num_epochs  = '0;
    axi.m_axi_ARREADY = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_arvalid", 64'(axi.m_axi_ARVALID), 64'd0);
    check("rst_araddr",  64'(axi.m_axi_ARADDR),  64'd0);
    check("rst_arid_len", 64'({axi.m_axi_ARID, axi.m_axi_ARLEN}), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_counters", 64'({ar_a_counter, ar_b_counter}), 64'd0);
    check("rst_stall", 64'(stall_counter), 64'd0);
    check("arsize_arburst", 64'({axi.m_axi_ARSIZE, axi.m_axi_ARBURST}), 64'b10101);
    rst_n = 1'b1;
    tick();

    // Single epoch: B 96 B -> 3 beats, A 1024 B -> 2 full bursts.
    push(B_BASE, IW'(MEM_RD_B_TAG), 4'd2);
    push(A_BASE, IW'(MEM_RD_A_TAG), 4'd15);
    push(A_BASE + 33'd512, IW'(MEM_RD_A_TAG), 4'd15);
    d0 = done_seen;
    do_start(32'd1024, 32'd96, 32'd1);
    check("latency_c1", 64'(axi.m_axi_ARVALID), 64'd0);
    check("busy_after_start", 64'(busy), 64'd1);
    tick();
    check("latency_c2", 64'(axi.m_axi_ARVALID), 64'd1);
    wait_done("single");
    check("single_counters", 64'({ar_a_counter, ar_b_counter}), {32'd2, 32'd1});
    check("single_done_once", 64'(done_seen - d0), 64'd1);
    check("single_queue_empty", 64'(exp_q.size()), 64'd0);

    // Partial tail: 530 B -> 17 beats; num_epochs=0 runs once.
    push(A_BASE, IW'(MEM_RD_A_TAG), 4'd15);
    push(A_BASE + 33'd512, IW'(MEM_RD_A_TAG), 4'd0);
    do_start(32'd530, 32'd0, 32'd0);
    wait_done("tail");
    check("tail_counters", 64'({ar_a_counter, ar_b_counter}), {32'd2, 32'd0});
    check("tail_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: burst held for 10 cycles with ARREADY low.
    axi.m_axi_ARREADY = 1'b0;
    push(A_BASE, IW'(MEM_RD_A_TAG), 4'd1);
    do_start(32'd64, 32'd0, 32'd1);
    i = 0;
    while (axi.m_axi_ARVALID !== 1'b1 && i < 10) begin
      tick();
      i++;
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", 64'({axi.m_axi_ARVALID, axi.m_axi_ARADDR, axi.m_axi_ARID, axi.m_axi_ARLEN}),
            64'({1'b1, A_BASE, IW'(MEM_RD_A_TAG), 4'd1}));
      tick();
    end
    axi.m_axi_ARREADY = 1'b1;
    wait_done("bp");
`ifdef HBM_RD_REQ_STATS_EN
    check("bp_stall_counter", 64'(stall_counter), 64'd10);
`else
    check("bp_stall_counter", 64'(stall_counter), 64'd0);
`endif
    check("bp_a_counter", 64'(ar_a_counter), 64'd1);

    // Credit limit: 4096 B -> 8 bursts, no RLAST returned.
    auto_rlast = 1'b0;
    for (int k = 0; k < 8; k++) push(A_BASE + AW'(k * 512), IW'(MEM_RD_A_TAG), 4'd15);
    h0 = hs_count;
    do_start(32'd4096, 32'd0, 32'd1);
    repeat (20) tick();
    check("credit_accepted4", 64'(hs_count - h0), 64'd4);
    check("credit_arvalid_low", 64'(axi.m_axi_ARVALID), 64'd0);
    check("credit_count4", 64'(dut.credit_count), 64'(model_out));
    rlast_req++;
    repeat (6) tick();
    check("credit_accepted5", 64'(hs_count - h0), 64'd5);
    check("credit_arvalid_low2", 64'(axi.m_axi_ARVALID), 64'd0);
    axi.m_axi_ARREADY = 1'b0;
    rlast_req++;
    repeat (4) tick();
    check("credit_held", 64'({axi.m_axi_ARVALID, axi.m_axi_ARADDR}), 64'({1'b1, A_BASE + 33'd2560}));
    check("credit_count3", 64'(dut.credit_count), 64'd3);
    axi.m_axi_ARREADY = 1'b1;
    rlast_req++;
    tick();
    check("credit_simul_unchanged", 64'(dut.credit_count), 64'd3);
    check("credit_next_burst", 64'({axi.m_axi_ARVALID, axi.m_axi_ARADDR}), 64'({1'b1, A_BASE + 33'd3072}));
    repeat (3) tick();
    check("credit_accepted7", 64'(hs_count - h0), 64'd7);
    auto_rlast = 1'b1;
    wait_done("credit");
    check("credit_a_counter", 64'(ar_a_counter), 64'd8);
    check("credit_queue_empty", 64'(exp_q.size()), 64'd0);

    // Multi-epoch: B,A three times; a start while busy must be ignored.
    chk_drain = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(B_BASE, IW'(MEM_RD_B_TAG), 4'd0);
      push(A_BASE, IW'(MEM_RD_A_TAG), 4'd15);
    end
    d0 = done_seen;
    do_start(32'd512, 32'd32, 32'd3);
    repeat (3) tick();
    addr_a      = 33'h0_4000_0000;
    data_length = 32'd4096;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    wait_done("epochs");
    chk_drain = 1'b0;
    check("epochs_counters", 64'({ar_a_counter, ar_b_counter}), {32'd3, 32'd3});
    check("epochs_done_once", 64'(done_seen - d0), 64'd1);
    check("epochs_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in ISSUE_A with 3 bursts outstanding.
    auto_rlast = 1'b0;
    for (int k = 0; k < 8; k++) push(A_BASE + AW'(k * 512), IW'(MEM_RD_A_TAG), 4'd15);
    do_start(32'd4096, 32'd0, 32'd1);
    i = 0;
    while (model_out != 3 && i < 50) begin
      tick();
      i++;
    end
    axi.m_axi_ARREADY = 1'b0;
    check("mid_outstanding3", 64'(dut.credit_count), 64'd3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_arvalid", 64'(axi.m_axi_ARVALID), 64'd0);
    check("mid_rst_ar", 64'({axi.m_axi_ARADDR, axi.m_axi_ARID, axi.m_axi_ARLEN}), 64'd0);
    check("mid_rst_busy_done", 64'({busy, done}), 64'd0);
    check("mid_rst_counters", 64'({ar_a_counter, ar_b_counter}), 64'd0);
    check("mid_rst_credit", 64'(dut.credit_count), 64'd0);
    rst_n = 1'b1;
    axi.m_axi_ARREADY = 1'b1;
    auto_rlast = 1'b1;
    tick();
    push(B_BASE, IW'(MEM_RD_B_TAG), 4'd0);
    push(A_BASE, IW'(MEM_RD_A_TAG), 4'd1);
    do_start(32'd64, 32'd32, 32'd1);
    wait_done("post_rst");
    check("post_rst_counters", 64'({ar_a_counter, ar_b_counter}), {32'd1, 32'd1});
    check("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
